// File: rtl/toy_pack.sv
// Shared constants and types for the fetch-path memory arbiter.
package toy_pack;

    localparam int FETCH_DATA_WIDTH        = 32;
    localparam int ICACHE_REQ_OPCODE_WIDTH = 2;
    localparam int MSHR_ENTRY_INDEX_WIDTH  = 2;
    localparam int ROB_ENTRY_ID_WIDTH      = 3;

    localparam int FETCH_ARB_MAX_OUTSTANDING = 4;
    localparam int FETCH_ARB_STARVE_LIMIT    = 3;

    // Which requester issued a fetch memory transaction.
    typedef enum logic {
        FETCH_SRC_DMD = 1'b0,
        FETCH_SRC_PF  = 1'b1
    } fetch_src_e;

endpackage

// File: rtl/toy_fetch_src_fifo.sv
// In-order record of which requester owns each outstanding fetch
// memory transaction. Pointers carry a wrap bit so full and empty are
// distinguishable without a separate counter.
module toy_fetch_src_fifo
    import toy_pack::*;
#(
    parameter int DEPTH = FETCH_ARB_MAX_OUTSTANDING
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  fetch_src_e push_src,
    input  logic       pop,
    output logic       full,
    output logic       empty,
    output fetch_src_e head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    fetch_src_e  mem [DEPTH];

    logic do_push;
    logic do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    // Advance the read and write pointers on accepted push/pop.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Capture the issuing source into the storage array.
    always_ff @(posedge clk) begin
        // NOTE: storage is left unreset; the pointers alone decide which entries are meaningful.
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_src;
    end

endmodule

// File: rtl/toy_fetch_mem_arb.sv
// Shares the fetch memory request/ack port between the demand (icache
// refill) and prefetch requesters. Demand has priority unless prefetch
// has waited through STARVE_LIMIT demand grants. A stalled grant is
// locked until it transfers, issue is capped at MAX_OUTSTANDING, and
// in-order acks are steered back using a source FIFO.
module toy_fetch_mem_arb
    import toy_pack::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = FETCH_DATA_WIDTH,
    parameter int ID_WIDTH        = 1 + ICACHE_REQ_OPCODE_WIDTH + MSHR_ENTRY_INDEX_WIDTH + ROB_ENTRY_ID_WIDTH,
    parameter int MAX_OUTSTANDING = FETCH_ARB_MAX_OUTSTANDING,
    parameter int STARVE_LIMIT    = FETCH_ARB_STARVE_LIMIT
) (
    input  logic                               clk,
    input  logic                               rst,

    input  logic                               dmd_req_vld,
    output logic                               dmd_req_rdy,
    input  logic [ADDR_WIDTH-1:0]              dmd_req_addr,
    input  logic [ID_WIDTH-1:0]                dmd_req_entry_id,

    input  logic                               pf_req_vld,
    output logic                               pf_req_rdy,
    input  logic [ADDR_WIDTH-1:0]              pf_req_addr,
    input  logic [ID_WIDTH-1:0]                pf_req_entry_id,

    output logic                               dmd_ack_vld,
    input  logic                               dmd_ack_rdy,
    output logic [DATA_WIDTH-1:0]              dmd_ack_data,
    output logic [ID_WIDTH-1:0]                dmd_ack_entry_id,

    output logic                               pf_ack_vld,
    input  logic                               pf_ack_rdy,
    output logic [DATA_WIDTH-1:0]              pf_ack_data,
    output logic [ID_WIDTH-1:0]                pf_ack_entry_id,

    output logic                               fetch_mem_req_vld,
    input  logic                               fetch_mem_req_rdy,
    output logic [ADDR_WIDTH-1:0]              fetch_mem_req_addr,
    output logic [ID_WIDTH-1:0]                fetch_mem_req_entry_id,

    input  logic                               fetch_mem_ack_vld,
    output logic                               fetch_mem_ack_rdy,
    input  logic [DATA_WIDTH-1:0]              fetch_mem_ack_data,
    input  logic [ID_WIDTH-1:0]                fetch_mem_ack_entry_id,

    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_cnt
);

    localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic          lock_vld;
    fetch_src_e    lock_src;
    logic [SW-1:0] starve_cnt;
    logic          starve_full;

    fetch_src_e    grant_src;
    logic          grant_vld;
    logic          slot_available;
    logic          req_xfer;
    logic          ack_xfer;

    logic          fifo_full;
    logic          fifo_empty;
    fetch_src_e    head_src;

    // Slot check uses only the registered count, so an ack never frees
    // a slot for an issue in the same cycle.
    assign slot_available = (outstanding_cnt < CW'(MAX_OUTSTANDING));
    assign starve_full    = (starve_cnt == SW'(STARVE_LIMIT));

    // Choose the granted requester: a held lock wins, then demand unless prefetch is starved.
    always_comb begin
        // NOTE: defaults first keep every path assigned, so no latch is inferred.
        grant_src = FETCH_SRC_DMD;
        grant_vld = 1'b0;
        if (lock_vld) begin
            grant_src = lock_src;
            grant_vld = (lock_src == FETCH_SRC_PF) ? pf_req_vld : dmd_req_vld;
        end else if (dmd_req_vld && !(starve_full && pf_req_vld)) begin
            grant_src = FETCH_SRC_DMD;
            grant_vld = 1'b1;
        end else if (pf_req_vld) begin
            grant_src = FETCH_SRC_PF;
            grant_vld = 1'b1;
        end
    end

    assign fetch_mem_req_vld      = grant_vld & slot_available;
    assign fetch_mem_req_addr     = (grant_src == FETCH_SRC_PF) ? pf_req_addr : dmd_req_addr;
    assign fetch_mem_req_entry_id = (grant_src == FETCH_SRC_PF) ? pf_req_entry_id : dmd_req_entry_id;

    assign dmd_req_rdy = grant_vld & (grant_src == FETCH_SRC_DMD) & fetch_mem_req_rdy & slot_available;
    assign pf_req_rdy  = grant_vld & (grant_src == FETCH_SRC_PF)  & fetch_mem_req_rdy & slot_available;

    assign req_xfer = fetch_mem_req_vld & fetch_mem_req_rdy;

    // Ack steering: the FIFO head names the owner; an ack with nothing
    // outstanding is refused and routed nowhere.
    assign dmd_ack_vld       = fetch_mem_ack_vld & ~fifo_empty & (head_src == FETCH_SRC_DMD);
    assign pf_ack_vld        = fetch_mem_ack_vld & ~fifo_empty & (head_src == FETCH_SRC_PF);
    assign fetch_mem_ack_rdy = ~fifo_empty & ((head_src == FETCH_SRC_PF) ? pf_ack_rdy : dmd_ack_rdy);
    assign ack_xfer          = fetch_mem_ack_vld & fetch_mem_ack_rdy;

    assign dmd_ack_data     = fetch_mem_ack_data;
    assign dmd_ack_entry_id = fetch_mem_ack_entry_id;
    assign pf_ack_data      = fetch_mem_ack_data;
    assign pf_ack_entry_id  = fetch_mem_ack_entry_id;

    toy_fetch_src_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_src_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (req_xfer),
        .push_src (grant_src),
        .pop      (ack_xfer),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head     (head_src)
    );

    // Hold the grant while the memory port stalls a presented request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_vld <= 1'b0;
            lock_src <= FETCH_SRC_DMD;
        end else begin
            lock_vld <= fetch_mem_req_vld & ~fetch_mem_req_rdy;
            if (fetch_mem_req_vld && !fetch_mem_req_rdy) lock_src <= grant_src;
        end
    end

    // Count demand grants that bypass a waiting prefetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!pf_req_vld || (req_xfer && grant_src == FETCH_SRC_PF)) begin
            starve_cnt <= '0;
        end else if (req_xfer && grant_src == FETCH_SRC_DMD && !starve_full) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Track in-flight transactions; simultaneous issue and ack cancel out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding_cnt <= '0;
        end else begin
            case ({req_xfer, ack_xfer})
                2'b10:   outstanding_cnt <= outstanding_cnt + 1'b1;
                2'b01:   outstanding_cnt <= outstanding_cnt - 1'b1;
                default: outstanding_cnt <= outstanding_cnt;
            endcase
        end
    end

    a_ack_without_req: assert property (@(posedge clk) disable iff (rst)
        !(fetch_mem_ack_vld && fifo_empty));

    a_fifo_overflow: assert property (@(posedge clk) disable iff (rst)
        !(req_xfer && fifo_full));

endmodule
